// File: rtl/bcd2bin_pkg.sv
// ---------------------------------------------------------------------------
// bcd2bin_pkg
// Shared types and constants for the sequential packed-BCD to binary
// converter (bcd_to_binary_seq_converter).
//   bcd2bin_state_e    : converter FSM states (IDLE, CONV, DONE)
//   BCD_DIGIT_W        : bits per BCD digit
//   MAX_DIGIT          : largest legal BCD digit value
//   bcd2bin_min_width  : smallest binary width that can hold 10**n - 1
// ---------------------------------------------------------------------------
package bcd2bin_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } bcd2bin_state_e;

  localparam int BCD_DIGIT_W = 4;
  localparam logic [BCD_DIGIT_W-1:0] MAX_DIGIT = 4'd9;

  // ceil(log2(10**n)): the narrowest width holding every n-digit decimal.
  function automatic int bcd2bin_min_width(input int n);
    longint p;
    int     w;
    p = 1;
    w = 0;
    for (int i = 0; i < n; i++) begin
      p = p * 10;
    end
    while ((longint'(1) << w) < p) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/bcd_to_binary_seq_converter_if.sv
// ---------------------------------------------------------------------------
// bcd_to_binary_seq_converter_if
// Handshake bundle for the BCD to binary converter.
//   in_valid  / in_ready  / bcd_in           : operand side
//   out_valid / out_ready / bin_out / err    : result side
// Modports:
//   master : the producer/consumer around the converter
//   slave  : the converter itself
// N_DIGITS and BIN_W must match the converter instance bound to it.
// ---------------------------------------------------------------------------
interface bcd_to_binary_seq_converter_if
  import bcd2bin_pkg::*;
#(
  parameter int N_DIGITS = 4,
  parameter int BIN_W    = 14
) ();

  logic                              in_valid;
  logic                              in_ready;
  logic [BCD_DIGIT_W*N_DIGITS-1:0]   bcd_in;
  logic                              out_valid;
  logic                              out_ready;
  logic [BIN_W-1:0]                  bin_out;
  logic                              err;

  modport master (
    output in_valid,
    output bcd_in,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  bin_out,
    input  err
  );

  modport slave (
    input  in_valid,
    input  bcd_in,
    input  out_ready,
    output in_ready,
    output out_valid,
    output bin_out,
    output err
  );

endinterface

// File: rtl/bcd2bin_mac10.sv
// ---------------------------------------------------------------------------
// bcd2bin_mac10
// Combinational multiply-by-ten-and-add step: acc_next = acc*10 + digit,
// built from two shifts and an add so no multiplier is inferred.
//   acc      in  ACC_W  running accumulator
//   digit    in  4      BCD digit consumed this step
//   acc_next out ACC_W  updated accumulator (wraps modulo 2**ACC_W)
//   invalid  out 1      digit is not a legal BCD value (> 9)
// ---------------------------------------------------------------------------
module bcd2bin_mac10
  import bcd2bin_pkg::*;
#(
  parameter int ACC_W = 18
) (
  input  logic [ACC_W-1:0]       acc,
  input  logic [BCD_DIGIT_W-1:0] digit,
  output logic [ACC_W-1:0]       acc_next,
  output logic                   invalid
);

  // acc*10 = acc*8 + acc*2
  assign acc_next = (acc << 3) + (acc << 1) + ACC_W'(digit);
  assign invalid  = (digit > MAX_DIGIT);

endmodule

// File: rtl/bcd_to_binary_seq_converter.sv
// ---------------------------------------------------------------------------
// bcd_to_binary_seq_converter
// Iterative packed-BCD to binary converter, one decimal digit per clock,
// most significant digit first, with valid/ready flow control on both sides.
//   clk  in  1      rising-edge clock
//   rst  in  1      asynchronous active-high reset
//   bus  slave modport of bcd_to_binary_seq_converter_if:
//        in_valid/in_ready/bcd_in, out_valid/out_ready/bin_out/err
// A result appears N_DIGITS clocks after the operand is accepted and is
// held until out_ready. While a result is being taken, a new operand can be
// accepted in the same cycle (in_ready follows out_ready in DONE).
// Optional feature macro: BCD2BIN_DIGIT_CHECK_EN
//   defined   : digits > 9 set a sticky err and force bin_out to 0
//   undefined : err tied to 0, digits used raw
// ---------------------------------------------------------------------------
module bcd_to_binary_seq_converter
  import bcd2bin_pkg::*;
#(
  parameter int N_DIGITS = 4,
  parameter int BIN_W    = 14
) (
  input  logic                           clk,
  input  logic                           rst,
  bcd_to_binary_seq_converter_if.slave   bus
);

  localparam int SR_W  = BCD_DIGIT_W * N_DIGITS;
  localparam int ACC_W = BIN_W + 4;
  localparam int CNT_W = $clog2(N_DIGITS + 1);

  // Elaboration-time parameter sanity.
  if (N_DIGITS < 1 || N_DIGITS > 9) begin : g_bad_digits
    $error("bcd_to_binary_seq_converter: N_DIGITS must be 1..9");
  end
  if (BIN_W < bcd2bin_min_width(N_DIGITS)) begin : g_bad_width
    $error("bcd_to_binary_seq_converter: BIN_W too narrow for N_DIGITS");
  end

  bcd2bin_state_e     state_reg, state_next;
  logic [SR_W-1:0]    sr_reg;
  logic [ACC_W-1:0]   acc_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [BIN_W-1:0]   bin_out_reg;

  logic               in_ready;
  logic               out_valid;
  logic               accept;
  logic               last_digit;
  logic [ACC_W-1:0]   acc_next;

  assign accept     = bus.in_valid && in_ready;
  assign last_digit = (cnt_reg == CNT_W'(N_DIGITS - 1));

`ifdef BCD2BIN_DIGIT_CHECK_EN
  logic digit_invalid;
  logic err_seen_reg;
  logic err_reg;
  logic err_final;

  // Includes the digit being consumed on the final CONV edge.
  assign err_final = err_seen_reg | digit_invalid;
`else
  logic unused_digit_invalid;
`endif

  bcd2bin_mac10 #(
    .ACC_W (ACC_W)
  ) u_mac10 (
    .acc      (acc_reg),
    .digit    (sr_reg[SR_W-1 -: BCD_DIGIT_W]),
    .acc_next (acc_next),
`ifdef BCD2BIN_DIGIT_CHECK_EN
    .invalid  (digit_invalid)
`else
    .invalid  (unused_digit_invalid)
`endif
  );

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------- FSM: next state and handshake outputs ----------------
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          state_next = CONV;
        end
      end
      CONV: begin
        if (last_digit) begin
          state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        // Back-to-back: a result being taken frees the converter this cycle.
        in_ready  = bus.out_ready;
        if (bus.out_ready) begin
          state_next = bus.in_valid ? CONV : IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------- Datapath ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_reg       <= '0;
      acc_reg      <= '0;
      cnt_reg      <= '0;
      bin_out_reg  <= '0;
`ifdef BCD2BIN_DIGIT_CHECK_EN
      err_seen_reg <= 1'b0;
      err_reg      <= 1'b0;
`endif
    end else if (state_reg == CONV) begin
      acc_reg <= acc_next;
      sr_reg  <= sr_reg << BCD_DIGIT_W;
      cnt_reg <= cnt_reg + 1'b1;
`ifdef BCD2BIN_DIGIT_CHECK_EN
      err_seen_reg <= err_final;
      if (last_digit) begin
        bin_out_reg <= err_final ? '0 : acc_next[BIN_W-1:0];
        err_reg     <= err_final;
      end
`else
      if (last_digit) begin
        bin_out_reg <= acc_next[BIN_W-1:0];
      end
`endif
    end else if (accept) begin
      // in_ready is low in CONV, so accept only happens from IDLE or DONE.
      sr_reg       <= bus.bcd_in;
      acc_reg      <= '0;
      cnt_reg      <= '0;
`ifdef BCD2BIN_DIGIT_CHECK_EN
      err_seen_reg <= 1'b0;
`endif
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.bin_out   = bin_out_reg;
`ifdef BCD2BIN_DIGIT_CHECK_EN
  assign bus.err       = err_reg;
`else
  assign bus.err       = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_to_binary_seq_converter.sv
// ---------------------------------------------------------------------------
// tb_bcd_to_binary_seq_converter
// Bench for bcd_to_binary_seq_converter with three instances:
//   index 0 : N_DIGITS=4, BIN_W=14
//   index 1 : N_DIGITS=1, BIN_W=4
//   index 2 : N_DIGITS=6, BIN_W=20
// A transaction-level model predicts every output each cycle; directed
// tests add literal expectations. Honours BCD2BIN_DIGIT_CHECK_EN.
// ---------------------------------------------------------------------------
module tb_bcd_to_binary_seq_converter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        iv   [3];
  logic        ordy [3];
  logic [35:0] bcd  [3];
  logic        ov   [3];
  logic        ir   [3];
  logic [31:0] bo   [3];
  logic        er   [3];

  int ndig [3] = '{4, 1, 6};
  int binw [3] = '{14, 4, 20};

  int checks = 0;
  int errors = 0;

  bcd_to_binary_seq_converter_if #(.N_DIGITS(4), .BIN_W(14)) if4 ();
  bcd_to_binary_seq_converter_if #(.N_DIGITS(1), .BIN_W(4))  if1 ();
  bcd_to_binary_seq_converter_if #(.N_DIGITS(6), .BIN_W(20)) if6 ();

  bcd_to_binary_seq_converter #(.N_DIGITS(4), .BIN_W(14)) dut4 (.clk(clk), .rst(rst), .bus(if4));
  bcd_to_binary_seq_converter #(.N_DIGITS(1), .BIN_W(4))  dut1 (.clk(clk), .rst(rst), .bus(if1));
  bcd_to_binary_seq_converter #(.N_DIGITS(6), .BIN_W(20)) dut6 (.clk(clk), .rst(rst), .bus(if6));

  assign if4.in_valid = iv[0];  assign if4.out_ready = ordy[0];  assign if4.bcd_in = bcd[0][15:0];
  assign if1.in_valid = iv[1];  assign if1.out_ready = ordy[1];  assign if1.bcd_in = bcd[1][3:0];
  assign if6.in_valid = iv[2];  assign if6.out_ready = ordy[2];  assign if6.bcd_in = bcd[2][23:0];

  assign ov[0] = if4.out_valid; assign ir[0] = if4.in_ready; assign bo[0] = 32'(if4.bin_out); assign er[0] = if4.err;
  assign ov[1] = if1.out_valid; assign ir[1] = if1.in_ready; assign bo[1] = 32'(if1.bin_out); assign er[1] = if1.err;
  assign ov[2] = if6.out_valid; assign ir[2] = if6.in_ready; assign bo[2] = 32'(if6.bin_out); assign er[2] = if6.err;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- Reference model (decimal arithmetic) ----------------
  function automatic bit has_bad_digit(input logic [35:0] v, input int n);
    bit bad = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (((v >> (4 * i)) & 36'hF) > 36'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  function automatic longint exp_bin(input logic [35:0] v, input int n, input int w);
    longint sum = 0;
    longint pw  = 1;
    for (int i = 0; i < n; i++) begin
      sum = sum + longint'((v >> (4 * i)) & 36'hF) * pw;
      pw  = pw * 10;
    end
`ifdef BCD2BIN_DIGIT_CHECK_EN
    if (has_bad_digit(v, n)) return 0;
`endif
    return sum & ((longint'(1) << w) - 1);
  endfunction

  function automatic bit exp_err(input logic [35:0] v, input int n);
`ifdef BCD2BIN_DIGIT_CHECK_EN
    return has_bad_digit(v, n);
`else
    return (n < 0) && has_bad_digit(v, 0);
`endif
  endfunction

  // 0 = idle, 1 = converting, 2 = result pending
  int     m_state [3];
  int     m_left  [3];
  longint m_pb    [3];
  bit     m_pe    [3];
  longint m_ob    [3];
  bit     m_oe    [3];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        m_state[i] <= 0;
        m_left[i]  <= 0;
        m_ob[i]    <= 0;
        m_oe[i]    <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (m_state[i] == 1) begin
          if (m_left[i] == 1) begin
            m_state[i] <= 2;
            m_ob[i]    <= m_pb[i];
            m_oe[i]    <= m_pe[i];
          end else begin
            m_left[i] <= m_left[i] - 1;
          end
        end else if (iv[i] && (m_state[i] == 0 || ordy[i])) begin
          m_state[i] <= 1;
          m_left[i]  <= ndig[i];
          m_pb[i]    <= exp_bin(bcd[i], ndig[i], binw[i]);
          m_pe[i]    <= exp_err(bcd[i], ndig[i]);
        end else if (m_state[i] == 2 && ordy[i]) begin
          m_state[i] <= 0;
        end
      end
    end
  end

  // ---------------- Per-cycle compare against the model ----------------
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("cmp%0d_out_valid", i), longint'(ov[i]), longint'(m_state[i] == 2));
      chk($sformatf("cmp%0d_in_ready", i), longint'(ir[i]),
          longint'(m_state[i] == 0 || (m_state[i] == 2 && ordy[i])));
      chk($sformatf("cmp%0d_bin_out", i), longint'(bo[i]), m_ob[i]);
      chk($sformatf("cmp%0d_err", i), longint'(er[i]), longint'(m_oe[i]));
    end
  end

  // ---------------- Directed helpers ----------------
  // Cycles counted from the accept cycle (=1) to the first out_valid cycle.
  task automatic wait_result(input int i, input int exp_lat, input longint exp_b,
                             input bit exp_e, input string name);
    int  cyc;
    bit  seen;
    cyc  = 1;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (ov[i]) seen = 1'b1;
      else       cyc++;
    end
    if (!seen) begin
      chk({name, "_timeout"}, 0, 1);
    end else begin
      chk({name, "_latency"}, cyc, exp_lat);
      chk({name, "_bin"}, longint'(bo[i]), exp_b);
      chk({name, "_err"}, longint'(er[i]), longint'(exp_e));
    end
    $display("txn %s: bcd=%h bin_out=%0d err=%0d latency=%0d", name, bcd[i], bo[i], er[i], cyc);
  endtask

  task automatic run_conv(input int i, input logic [35:0] v, input int exp_lat,
                          input longint exp_b, input bit exp_e, input string name);
    @(posedge clk); #1;
    iv[i]  = 1'b1;
    bcd[i] = v;
    @(negedge clk);
    chk({name, "_ready_before_accept"}, longint'(ir[i]), 1);
    @(posedge clk); #1;
    iv[i] = 1'b0;
    wait_result(i, exp_lat, exp_b, exp_e, name);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      iv[i] = 1'b0; ordy[i] = 1'b1; bcd[i] = '0;
    end

    // Reset state
    @(posedge clk); #1;
    chk("reset_out_valid", longint'(ov[0]), 0);
    chk("reset_in_ready",  longint'(ir[0]), 1);
    chk("reset_bin_out",   longint'(bo[0]), 0);
    chk("reset_err",       longint'(er[0]), 0);
    @(posedge clk); #2;
    rst = 1'b0;

    // 1. Basic conversion
    run_conv(0, 36'h1234, 5, 1234, 1'b0, "t1_1234");

    // 2. Extremes
    run_conv(0, 36'h9999, 5, 14'h270F, 1'b0, "t2_9999");
    run_conv(0, 36'h0000, 5, 0, 1'b0, "t2_0000");

    // 3. Back-pressure then same-cycle accept from DONE
    @(posedge clk); #1;
    ordy[0] = 1'b0;
    run_conv(0, 36'h1234, 5, 1234, 1'b0, "t3_hold");
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("t3_hold_out_valid", longint'(ov[0]), 1);
      chk("t3_hold_bin",       longint'(bo[0]), 1234);
      chk("t3_hold_in_ready",  longint'(ir[0]), 0);
    end
    @(posedge clk); #1;
    ordy[0] = 1'b1;
    iv[0]   = 1'b1;
    bcd[0]  = 36'h0042;
    @(negedge clk);
    chk("t3_accept_in_done", longint'(ir[0]), 1);
    @(posedge clk); #1;
    iv[0] = 1'b0;
    wait_result(0, 5, 42, 1'b0, "t3_0042");

    // 4. Illegal digit
`ifdef BCD2BIN_DIGIT_CHECK_EN
    run_conv(0, 36'h12A4, 5, 0, 1'b1, "t4_12A4");
`else
    run_conv(0, 36'h12A4, 5, 1304, 1'b0, "t4_12A4");
`endif

    // 5. Asynchronous reset in the 3rd CONV cycle
    @(posedge clk); #1;
    iv[0]  = 1'b1;
    bcd[0] = 36'h5678;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("t5_rst_out_valid", longint'(ov[0]), 0);
    chk("t5_rst_in_ready",  longint'(ir[0]), 1);
    chk("t5_rst_bin_out",   longint'(bo[0]), 0);
    chk("t5_rst_err",       longint'(er[0]), 0);
    $display("txn t5_reset: out_valid=%0d in_ready=%0d bin_out=%0d", ov[0], ir[0], bo[0]);
    #2;
    rst = 1'b0;
    run_conv(0, 36'h0007, 5, 7, 1'b0, "t5_0007");

    // 6. Other geometries
    for (int d = 0; d < 10; d++) begin
      run_conv(1, 36'(d), 2, d, 1'b0, $sformatf("t6_n1_d%0d", d));
    end
    run_conv(2, 36'h999999, 7, 20'hF423F, 1'b0, "t6_n6_999999");
    run_conv(2, 36'h000001, 7, 1, 1'b0, "t6_n6_000001");

    repeat (3) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
